// File: rtl/bridge_reg_responder_pkg.sv
// pocket: shared bridge types and window decode helper for bridge leaves
package pocket;
    typedef logic [31:0] bridge_addr_t;
    typedef logic [31:0] bridge_data_t;
    localparam int BRIDGE_WORD_LSB = 2;
    function automatic logic bridge_in_window(bridge_addr_t a, bridge_addr_t base, int idx_w);
        bridge_addr_t m;
        m = '1 << (idx_w + BRIDGE_WORD_LSB);
        return ((a ^ base) & m) == '0;
    endfunction
endpackage

// File: rtl/bridge_reg_responder_if.sv
// bridge_if: pocket bridge access signals between an initiator and a leaf responder
interface bridge_if;
    import pocket::*;
    bridge_addr_t addr;
    bridge_data_t wr_data;
    bridge_data_t rd_data;
    logic wr;
    logic rd;
    modport master (output addr, wr_data, wr, rd, input rd_data);
    modport slave (input addr, wr_data, wr, rd, output rd_data);
endinterface

// File: rtl/bridge_reg_responder_addr_decode.sv
// bridge_addr_decode: combinational window hit and word index for a bridge leaf
module bridge_addr_decode
    import pocket::*;
#(
    parameter bridge_addr_t BASE_ADDR = '0,
    parameter int NUM_REGS = 8,
    localparam int IDX_W = $clog2(NUM_REGS)
) (
    input  bridge_addr_t     addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);
    assign hit = bridge_in_window(addr, BASE_ADDR, IDX_W);
    assign idx = addr[IDX_W+BRIDGE_WORD_LSB-1:BRIDGE_WORD_LSB];
endmodule

// File: rtl/bridge_reg_responder.sv
// bridge_reg_responder: bridge leaf exposing control, live status and sticky W1C registers
module bridge_reg_responder
    import pocket::*;
#(
    parameter bridge_addr_t BASE_ADDR = '0,
    parameter int NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0,
    parameter logic [NUM_REGS-1:0] STICKY_MASK = '0
) (
    input  logic                clk,
    input  logic                reset,
    bridge_if.slave             bridge,
    output bridge_data_t        ctrl_out [NUM_REGS],
    input  bridge_data_t        status_in [NUM_REGS],
    output logic [NUM_REGS-1:0] wr_pulse,
    output logic [NUM_REGS-1:0] rd_pulse
);
    localparam int IDX_W = $clog2(NUM_REGS);
    logic hit;
    logic [IDX_W-1:0] idx;
    logic [NUM_REGS-1:0] wr_sel, rd_sel;
    bridge_data_t sticky [NUM_REGS];
    bridge_data_t value [NUM_REGS];
    bridge_addr_decode #(.BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS)) u_dec (
        .addr(bridge.addr),
        .hit (hit),
        .idx (idx)
    );
    assign wr_sel = (bridge.wr && hit) ? NUM_REGS'(1) << idx : '0;
    assign rd_sel = (bridge.rd && hit) ? NUM_REGS'(1) << idx : '0;
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++)
            value[i] = RO_MASK[i] ? (STICKY_MASK[i] ? sticky[i] : status_in[i]) : ctrl_out[i];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                ctrl_out[i] <= '0;
                sticky[i] <= '0;
            end
            bridge.rd_data <= '0;
            wr_pulse <= '0;
            rd_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (!RO_MASK[i] && wr_sel[i]) ctrl_out[i] <= bridge.wr_data;
                sticky[i] <= (RO_MASK[i] && STICKY_MASK[i]) ?
                    ((sticky[i] & ~(wr_sel[i] ? bridge.wr_data : '0)) | status_in[i]) : '0;
            end
            wr_pulse <= wr_sel;
            rd_pulse <= rd_sel;
            if (bridge.rd) bridge.rd_data <= hit ? value[idx] : '0;
        end
    end
endmodule

// File: tb/tb_bridge_reg_responder.sv
// tb_bridge_reg_responder: directed stimulus checked against a behavioural register-bank model
module tb_bridge_reg_responder;
    import pocket::*;
    localparam bridge_addr_t BASE = 32'h1000;
    localparam int N = 8;
    localparam logic [N-1:0] RO = 8'b0001_1000;
    localparam logic [N-1:0] STK = 8'b0000_1000;
    logic clk = 0;
    logic reset;
    bridge_if bus();
    bridge_data_t ctrl [N];
    bridge_data_t status [N];
    logic [N-1:0] wp, rp;
    int checks = 0;
    int errors = 0;
    bridge_reg_responder #(.BASE_ADDR(BASE), .NUM_REGS(N), .RO_MASK(RO), .STICKY_MASK(STK)) dut (
        .clk(clk),
        .reset(reset),
        .bridge(bus),
        .ctrl_out(ctrl),
        .status_in(status),
        .wr_pulse(wp),
        .rd_pulse(rp)
    );
    always #5 clk = ~clk;
    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction
    bridge_data_t m_ctrl [N];
    bridge_data_t m_st;
    bridge_data_t m_rd;
    logic [N-1:0] m_wp, m_rp;
    logic chk_en = 0;
    always @(posedge clk) begin
        logic in_win;
        int k;
        bridge_data_t v;
        in_win = bus.addr >= BASE && bus.addr < BASE + N * 4;
        k = int'((bus.addr - BASE) >> 2);
        if (reset) begin
            for (int i = 0; i < N; i++) m_ctrl[i] <= '0;
            m_st <= '0;
            m_rd <= '0;
            m_wp <= '0;
            m_rp <= '0;
            chk_en <= 1;
        end else begin
            m_wp <= '0;
            m_rp <= '0;
            if (bus.rd) begin
                v = '0;
                if (in_win) v = (k == 3) ? m_st : (k == 4) ? status[4] : m_ctrl[k];
                m_rd <= v;
                if (in_win) m_rp[k] <= 1'b1;
            end
            if (bus.wr && in_win) begin
                m_wp[k] <= 1'b1;
                if (k != 3 && k != 4) m_ctrl[k] <= bus.wr_data;
            end
            m_st <= ((bus.wr && in_win && k == 3) ? (m_st & ~bus.wr_data) : m_st) | status[3];
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) check($sformatf("model_ctrl%0d", i), ctrl[i], m_ctrl[i]);
            check("model_rd_data", bus.rd_data, m_rd);
            check("model_wr_pulse", 32'(wp), 32'(m_wp));
            check("model_rd_pulse", 32'(rp), 32'(m_rp));
        end
    end
    task automatic drive(input logic w, input logic r, input bridge_addr_t a, input bridge_data_t d);
        bus.wr = w;
        bus.rd = r;
        bus.addr = a;
        bus.wr_data = d;
        @(posedge clk);
        #1;
    endtask
    initial begin
        for (int i = 0; i < N; i++) status[i] = '0;
        reset = 1;
        drive(1, 1, BASE, 32'hFFFF_FFFF);
        drive(1, 1, BASE, 32'hFFFF_FFFF);
        check("reset_rd_data", bus.rd_data, 32'h0);
        check("reset_ctrl0", ctrl[0], 32'h0);
        check("reset_pulses", 32'({wp, rp}), 32'h0);
        reset = 0;
        drive(0, 0, BASE, 0);
        drive(1, 0, 32'h1004, 32'hDEAD_BEEF);
        check("wr_ctrl1", ctrl[1], 32'hDEAD_BEEF);
        check("wr_pulse1", 32'(wp), 32'h02);
        drive(0, 1, 32'h1004, 0);
        check("rd_ctrl1", bus.rd_data, 32'hDEAD_BEEF);
        check("wr_pulse_one_cycle", 32'(wp), 32'h0);
        check("rd_pulse1", 32'(rp), 32'h02);
        drive(0, 1, 32'h2000, 0);
        check("rd_miss_data", bus.rd_data, 32'h0);
        check("rd_miss_pulse", 32'(rp), 32'h0);
        drive(1, 0, 32'h1020, 32'h1234_5678);
        check("wr_miss_ctrl0", ctrl[0], 32'h0);
        check("wr_miss_pulse", 32'(wp), 32'h0);
        status[3] = 32'h5;
        drive(0, 0, BASE, 0);
        status[3] = 32'h0;
        drive(0, 1, 32'h100C, 0);
        check("sticky_set", bus.rd_data, 32'h5);
        drive(1, 0, 32'h100C, 32'h1);
        drive(0, 1, 32'h100C, 0);
        check("sticky_w1c", bus.rd_data, 32'h4);
        status[3] = 32'h1;
        drive(1, 0, 32'h100C, 32'h1);
        status[3] = 32'h0;
        drive(0, 1, 32'h100C, 0);
        check("sticky_collision", bus.rd_data, 32'h5);
        status[4] = 32'hA5A5_0004;
        drive(1, 0, 32'h1010, 32'hFFFF_FFFF);
        check("ro_wr_pulse", 32'(wp), 32'h10);
        check("ro_ctrl_zero", ctrl[4], 32'h0);
        drive(0, 1, 32'h1012, 0);
        check("ro_live_status", bus.rd_data, 32'hA5A5_0004);
        drive(1, 0, 32'h1000, 32'h11);
        drive(1, 0, 32'h1008, 32'h33);
        drive(0, 1, 32'h1000, 0);
        check("b2b_rd0", bus.rd_data, 32'h11);
        check("b2b_rp0", 32'(rp), 32'h01);
        drive(1, 1, 32'h1004, 32'hCAFE_F00D);
        check("b2b_rd1_prewrite", bus.rd_data, 32'hDEAD_BEEF);
        check("b2b_rp1", 32'(rp), 32'h02);
        check("b2b_ctrl1", ctrl[1], 32'hCAFE_F00D);
        drive(0, 1, 32'h1008, 0);
        check("b2b_rd2", bus.rd_data, 32'h33);
        check("b2b_rp2", 32'(rp), 32'h04);
        drive(0, 0, 32'h1004, 0);
        check("rd_hold", bus.rd_data, 32'h33);
        reset = 1;
        drive(1, 1, 32'h1004, 32'h0);
        check("reset2_ctrl1", ctrl[1], 32'h0);
        check("reset2_rd_data", bus.rd_data, 32'h0);
        reset = 0;
        drive(0, 0, BASE, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bridge_reg_responder.md
# bridge_reg_responder

Bridge-side responder that terminates one address window of the pocket bridge and exposes a small register bank to the core. It decodes `bridge.addr`, services bridge writes into control registers or write-1-to-clear sticky status bits, and answers bridge reads with registered `rd_data`. It sits at a leaf of the bridge distribution tree; the bridge connect macros feed it. Out-of-window reads return zero, so several responders can share one tree with their `rd_data` ORed together.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of register 0. Must be aligned to the window size, NUM_REGS*4 bytes.
- `NUM_REGS`, 8: number of 32-bit registers. Must be a power of 2, from 2 to 64.
- `RO_MASK`, '0: NUM_REGS bits. Bit i = 1 makes register i read-only status. Bit i = 0 makes it a read/write control register.
- `STICKY_MASK`, '0: NUM_REGS bits. Only meaningful where RO_MASK=1. Bit i = 1 makes register i sticky and write-1-to-clear.

Ports:
- `clk`, input, 1: sole clock.
- `reset`, input, 1: synchronous, active-high.
- `bridge`, bridge_if, –: responder end. Consumes `addr`, `wr_data`, `wr`, `rd`; drives `rd_data`.
- `ctrl_out`, output, NUM_REGS x 32: control register contents. Entries with RO_MASK=1 are held at 0.
- `status_in`, input, NUM_REGS x 32: core status. Used only where RO_MASK=1.
- `wr_pulse`, output, NUM_REGS: one-cycle strobe after an accepted write to register i.
- `rd_pulse`, output, NUM_REGS: one-cycle strobe after a read of register i, for pop-on-read use.

## Operation
- **Decode:** hit = (addr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]), with IDX_W = $clog2(NUM_REGS). idx = addr[IDX_W+1:2]. addr[1:0] is ignored.
- **RW register, write hit:** ctrl_out[idx] <= wr_data.
- **Plain RO register:** reads return live status_in[idx]. Writes are ignored but still pulse wr_pulse.
- **Sticky register:** each cycle, sticky[i] <= (sticky[i] & ~clr) | status_in[i].
  - clr = wr_data on a write hit to i, otherwise 0.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Reads return sticky[i].
- **Read:** on every cycle with rd=1, rd_data <= hit ? value[idx] : 0. With rd=0, rd_data holds its value.
- **Misses:** wr miss has no effect and produces no pulse. rd miss returns 0 and produces no pulse.
- **rd and wr in the same cycle:** both are serviced. The read returns the pre-write value.
- **Reset:** the following all go to 0 on the first clk edge with reset=1.
  - ctrl_out, every sticky register, rd_data, wr_pulse, rd_pulse.
  - wr or rd asserted during a reset cycle is dropped: no pulse, and rd_data stays 0.

## Timing
- **Read latency:** rd at edge N gives rd_data valid from N+1. It holds until the next rd.
  - The bridge must not sample earlier than N+1.
- **Write:** wr at edge N updates ctrl_out at N+1, and wr_pulse[idx] is high for exactly cycle N+1.
- **rd_pulse:** high for exactly cycle N+1 after a read hit at N.
- **Back-to-back accesses** are accepted every cycle with no stall and no back-pressure.
- **Sticky set:** status_in high at edge N is readable by a rd at N+1 or later.
- **Read/set collision:** a rd at N returns the state before N's set.
- **Outputs are registered:** no combinational path from bridge inputs to any output.

## Structure
- **Package `pocket`:** add `localparam int BRIDGE_WORD_LSB = 2`. Also add `function automatic bridge_in_window(bridge_addr_t a, bridge_addr_t base, int idx_w)`, shared with the other leaves. Reuse the existing `bridge_addr_t` and `bridge_data_t`.
- **Sub-module `bridge_addr_decode`:** purely combinational. Parameters BASE_ADDR and NUM_REGS; input addr; outputs hit and idx. It will be reused by future bridge leaves such as a RAM window.
- **Top level:** holds the register array, the sticky logic, the rd_data register and the pulse flops.

## Test plan
- **Reset:** assert reset 2 cycles with wr=1, rd=1, addr=BASE.
  - Expect ctrl_out=0, rd_data=0 and no pulses.
- **Write then read:** BASE=32'h1000, wr at 32'h1004 with 32'hDEADBEEF.
  - Expect ctrl_out[1]=DEADBEEF and wr_pulse[1] high one cycle.
  - A following rd at 32'h1004 gives rd_data=DEADBEEF one cycle later.
- **Miss:** rd at 32'h2000.
  - Expect rd_data=0 and no rd_pulse.
  - Then wr at 32'h1020 (just past 8 registers) changes no ctrl_out.
- **Sticky W1C:** STICKY on reg 3; pulse status_in[3]=32'h5 for one cycle.
  - Read gives 5. Write 32'h1 then read gives 4.
- **Sticky collision:** same-cycle status_in[3] bit0=1 and write-1 clear of bit0.
  - Expect bit0 stays 1.
- **Back-to-back:** rd idx 0,1,2 on consecutive cycles, with a same-cycle wr to reg 1.
  - Expect rd_data to track one cycle late and return the pre-write value for reg 1.
  - Expect rd_pulse[0..2] in sequence.
